data_mem_mmio: RTL and testbench

//  Data-side memory system downstream of the single-cycle core's load/store port.

---
 rtl/data_mem_mmio.sv | 147 ++++++++++++++
 tb/tb_data_mem_mmio.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data-side memory system for the single-cycle core: word RAM, console TX FIFO and machine timer.
// Loads are combinational from the address and stores commit on the clock edge.
module data_mem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_write_enable,
  input  logic [31:0] ALUResult,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq_timer
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);

  typedef enum logic [1:0] {
    REG_TXDATA   = 2'd0,
    REG_STATUS   = 2'd1,
    REG_MTIME    = 2'd2,
    REG_MTIMECMP = 2'd3
  } mmio_reg_e;

  logic [31:0]      ram [RAM_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [31:0]      mtime;
  logic [31:0]      mtimecmp;

  logic              ram_sel;
  logic              mmio_sel;
  mmio_reg_e         mmio_reg;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              push_req;
  logic              status_we;
  logic              mtime_we;
  logic              mtimecmp_we;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              overflow_set;

  // Address decode; the MMIO window is 16-byte aligned so bits [3:2] pick the register.
  always_comb begin
    ram_sel     = ALUResult < RAM_LIMIT;
    mmio_sel    = ALUResult[31:4] == MMIO_BASE[31:4];
    mmio_reg    = mmio_reg_e'(ALUResult[3:2]);
    ram_idx     = ALUResult[RAM_AW+1:2];
    ram_we      = data_mem_write_enable && ram_sel;
    push_req    = data_mem_write_enable && mmio_sel && (mmio_reg == REG_TXDATA);
    status_we   = data_mem_write_enable && mmio_sel && (mmio_reg == REG_STATUS);
    mtime_we    = data_mem_write_enable && mmio_sel && (mmio_reg == REG_MTIME);
    mtimecmp_we = data_mem_write_enable && mmio_sel && (mmio_reg == REG_MTIMECMP);
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full         = count == CNT_W'(FIFO_DEPTH);
    empty        = count == '0;
    pop          = !empty && tx_ready;
    push         = push_req && (!full || pop);
    overflow_set = push_req && full && !pop;
  end

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= data_mem_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= data_mem_write_data[7:0];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (status_we) begin
        overflow <= 1'b0;
      end
    end
  end

  // Machine timer: a store to MTIME overrides that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime     <= 32'h0000_0000;
      mtimecmp  <= 32'hFFFF_FFFF;
      irq_timer <= 1'b0;
    end else begin
      mtime     <= mtime_we ? data_mem_write_data : mtime + 32'd1;
      irq_timer <= mtime >= mtimecmp;
      if (mtimecmp_we) begin
        mtimecmp <= data_mem_write_data;
      end
    end
  end

  always_comb begin
    data_mem_read_data = 32'h0000_0000;
    if (ram_sel) begin
      data_mem_read_data = ram[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_reg)
        REG_STATUS:   data_mem_read_data = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};
        REG_MTIME:    data_mem_read_data = mtime;
        REG_MTIMECMP: data_mem_read_data = mtimecmp;
        default:      data_mem_read_data = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: vector table for RAM/decode, scoreboard for the TX stream,
// hand sequences for FIFO corner cases, timer compare, wrap and asynchronous reset.
module tb_data_mem_mmio;

  localparam int unsigned DEPTH       = 4;
  localparam logic [31:0] A_TXDATA    = 32'h8000_0000;
  localparam logic [31:0] A_STATUS    = 32'h8000_0004;
  localparam logic [31:0] A_MTIME     = 32'h8000_0008;
  localparam logic [31:0] A_MTIMECMP  = 32'h8000_000C;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq_timer;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_mem_mmio #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(DEPTH),
    .MMIO_BASE (32'h8000_0000)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .data_mem_write_enable(we),
    .ALUResult            (addr),
    .data_mem_write_data  (wdata),
    .data_mem_read_data   (rdata),
    .tx_valid             (tx_valid),
    .tx_data              (tx_data),
    .tx_ready             (tx_ready),
    .irq_timer            (irq_timer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] e, input string n);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.chk = c; v.exp = e; v.name = n;
    return v;
  endfunction

  // Scoreboard for the TX stream: handshakes are sampled mid-cycle and commit at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      logic popped;
      popped = (sb_q.size() != 0) && tx_ready;
      check("tx_valid", {31'b0, tx_valid}, (sb_q.size() != 0) ? 32'd1 : 32'd0);
      if (popped) begin
        check("tx_data", {24'b0, tx_data}, {24'b0, sb_q[0]});
        void'(sb_q.pop_front());
      end
      if (we && addr == A_TXDATA && sb_q.size() < DEPTH) begin
        sb_q.push_back(wdata[7:0]);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    drive(1'b0, A_STATUS, 32'h0);
    #2;
    check("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset tx_data", {24'b0, tx_data}, 32'd0);
    check("reset irq", {31'b0, irq_timer}, 32'd0);
    check("reset status", rdata, 32'h0000_0002);
    addr = A_MTIME;    #1; check("reset mtime", rdata, 32'h0);
    addr = A_MTIMECMP; #1; check("reset mtimecmp", rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #3 reset = 1'b0;
    cyc();

    // RAM and address decode
    vecs.push_back(mk(1, 32'h10,        32'hDEAD_BEEF, 0, 32'h0,         "wr 10"));
    vecs.push_back(mk(0, 32'h10,        32'h0,         1, 32'hDEAD_BEEF, "rd 10"));
    vecs.push_back(mk(0, 32'h13,        32'h0,         1, 32'hDEAD_BEEF, "rd 13"));
    vecs.push_back(mk(1, 32'h0,         32'h1122_3344, 0, 32'h0,         "wr 0"));
    vecs.push_back(mk(1, 32'hFC,        32'hCAFE_F00D, 0, 32'h0,         "wr fc"));
    vecs.push_back(mk(0, 32'h0,         32'h0,         1, 32'h1122_3344, "rd 0"));
    vecs.push_back(mk(0, 32'hFC,        32'h0,         1, 32'hCAFE_F00D, "rd fc"));
    vecs.push_back(mk(1, 32'h100,       32'h0000_0055, 0, 32'h0,         "wr 100"));
    vecs.push_back(mk(0, 32'h100,       32'h0,         1, 32'h0,         "rd 100"));
    vecs.push_back(mk(0, 32'h0,         32'h0,         1, 32'h1122_3344, "rd 0 alias"));
    vecs.push_back(mk(1, 32'h4000_0000, 32'h0000_ABCD, 0, 32'h0,         "wr unmapped"));
    vecs.push_back(mk(0, 32'h4000_0000, 32'h0,         1, 32'h0,         "rd unmapped"));
    vecs.push_back(mk(0, 32'h10,        32'h0,         1, 32'hDEAD_BEEF, "rd 10 again"));
    vecs.push_back(mk(0, A_TXDATA,      32'h0,         1, 32'h0,         "rd txdata"));
    vecs.push_back(mk(0, 32'h8000_0010, 32'h0,         1, 32'h0,         "rd past mmio"));
    vecs.push_back(mk(0, A_STATUS,      32'h0,         1, 32'h0000_0002, "rd status"));
    vecs.push_back(mk(0, A_MTIMECMP,    32'h0,         1, 32'hFFFF_FFFF, "rd mtimecmp"));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk) check(vecs[i].name, rdata, vecs[i].exp);
      cyc();
    end

    // FIFO fill past full, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, A_TXDATA, 32'h41 + 32'(i));
      cyc();
    end
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status full+ovf", rdata, 32'h0000_0405);
    check("head byte", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("drained valid", {31'b0, tx_valid}, 32'd0);
    check("status drained", rdata, 32'h0000_0006);
    tx_ready = 1'b0;

    // Clear overflow, refill, simultaneous push/pop while full
    drive(1'b1, A_STATUS, 32'h0);
    cyc();
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status cleared", rdata, 32'h0000_0002);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, A_TXDATA, 32'h61 + 32'(i));
      cyc();
    end
    tx_ready = 1'b1;
    drive(1'b1, A_TXDATA, 32'h55);
    cyc();
    tx_ready = 1'b0;
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status simul", rdata, 32'h0000_0401);
    drive(1'b1, A_TXDATA, 32'h66);
    cyc();
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status drop", rdata, 32'h0000_0405);
    drive(1'b1, A_STATUS, 32'h0);
    cyc();
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status ovf clr", rdata, 32'h0000_0401);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    tx_ready = 1'b0;
    check("status empty", rdata, 32'h0000_0002);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    // Timer compare
    drive(1'b1, A_MTIME, 32'h0);
    cyc();
    drive(1'b1, A_MTIMECMP, 32'd20);
    cyc();
    for (int k = 1; k <= 24; k++) begin
      drive(1'b0, A_MTIME, 32'h0);
      #1;
      check("mtime count", rdata, 32'(k));
      check("irq rise", {31'b0, irq_timer}, (k >= 21) ? 32'd1 : 32'd0);
      cyc();
    end
    drive(1'b1, A_MTIMECMP, 32'hFFFF_FFFF);
    cyc();
    drive(1'b0, A_MTIME, 32'h0);
    #1;
    check("irq hold", {31'b0, irq_timer}, 32'd1);
    cyc();
    check("irq drop", {31'b0, irq_timer}, 32'd0);

    // mtime wrap
    drive(1'b1, A_MTIME, 32'hFFFF_FFFE);
    cyc();
    drive(1'b0, A_MTIME, 32'h0);
    #1;
    check("mtime load", rdata, 32'hFFFF_FFFE);
    cyc(); check("mtime max", rdata, 32'hFFFF_FFFF);
    cyc(); check("mtime wrap", rdata, 32'h0);
    cyc(); check("mtime resume", rdata, 32'h1);

    // Asynchronous reset with bytes in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, A_TXDATA, 32'h71 + 32'(i));
      cyc();
    end
    drive(1'b0, A_STATUS, 32'h0);
    #1;
    check("status 3", rdata, 32'h0000_0300);
    #1 reset = 1'b1;
    #1;
    sb_q.delete();
    check("rst tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst tx_data", {24'b0, tx_data}, 32'd0);
    check("rst status", rdata, 32'h0000_0002);
    addr = A_MTIME;
    #1;
    check("rst mtime", rdata, 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("post rst mtime", rdata, 32'h0);
    check("post rst irq", {31'b0, irq_timer}, 32'd0);
    addr = 32'h10;
    #1;
    check("ram kept", rdata, 32'hDEAD_BEEF);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
